// File: rtl/smart_cargo_fila_n.sv
// Route-ordered stop queue for the SmartCargo elevator: each request becomes a
// pickup and a drop-off stop, each inserted where it fits along the planned route.
module smart_cargo_fila_n #(
   parameter int ANDAR_BITS = 2,
   parameter int TIPO_BITS  = 2,
   parameter int DEPTH      = 16,
   parameter int ADDR_BITS  = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              clear,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [ANDAR_BITS-1:0]             req_origem,
   input  logic [ANDAR_BITS-1:0]             req_destino,
   input  logic [TIPO_BITS-1:0]              req_tipo,
   input  logic [ANDAR_BITS-1:0]             andar_atual,
   input  logic                              pop,
   output logic                              head_valid,
   output logic [ANDAR_BITS-1:0]             head_andar,
   output logic                              head_eh_origem,
   output logic [TIPO_BITS-1:0]              head_tipo,
   output logic [ADDR_BITS:0]                count,
   output logic                              busy,
   output logic                              erro,
   input  logic [ADDR_BITS-1:0]              dbg_addr,
   output logic [TIPO_BITS+ANDAR_BITS:0]     dbg_dados
);

   localparam int ENTRY_W = 1 + TIPO_BITS + ANDAR_BITS;
   localparam int CNT_W   = ADDR_BITS + 1;

   typedef enum logic [2:0] {
      IDLE,
      BUSCA_O,
      INSERE_O,
      BUSCA_D,
      INSERE_D
   } state_t;

   state_t                state, state_nx;
   logic [CNT_W-1:0]      k, k_nx;
   logic [CNT_W-1:0]      cnt;
   logic [ENTRY_W-1:0]    mem [DEPTH];
   logic [ANDAR_BITS-1:0] lat_o, lat_d;
   logic [TIPO_BITS-1:0]  lat_t;
   logic                  lat_up;
   logic                  pend;

   logic                  accept;
   logic                  pop_now;
   logic [ADDR_BITS-1:0]  k_idx;
   logic [ANDAR_BITS-1:0] stop_andar, prev_andar, nxt_andar;
   logic                  asc, desc, fit_o, fit_d, at_end;
   logic [ENTRY_W-1:0]    new_entry;

   assign busy      = (state != IDLE);
   assign req_ready = !busy && (cnt <= CNT_W'(DEPTH - 2));
   assign accept    = req_valid && req_ready && (req_origem != req_destino) && (req_tipo != '0);
   assign pop_now   = !busy && (pop || pend) && (cnt != '0);

   assign head_valid     = (cnt != '0);
   assign head_eh_origem = mem[0][ENTRY_W-1];
   assign head_tipo      = mem[0][ANDAR_BITS +: TIPO_BITS];
   assign head_andar     = mem[0][ANDAR_BITS-1:0];
   assign count          = cnt;
   assign dbg_dados      = ({1'b0, dbg_addr} < cnt) ? mem[dbg_addr] : '0;

   // Segment fit: the stop must lie strictly between the previous and next floors.
   assign k_idx      = k[ADDR_BITS-1:0];
   assign stop_andar = (state == BUSCA_O) ? lat_o : lat_d;
   assign prev_andar = (k == '0) ? andar_atual : mem[k_idx - 1'b1][ANDAR_BITS-1:0];
   assign nxt_andar  = mem[k_idx][ANDAR_BITS-1:0];
   assign asc        = (prev_andar < stop_andar) && (stop_andar < nxt_andar);
   assign desc       = (prev_andar > stop_andar) && (stop_andar > nxt_andar);
   assign fit_o      = (asc && lat_up) || (desc && !lat_up);
   assign fit_d      = asc || desc;
   assign at_end     = (k == cnt);
   assign new_entry  = (state == INSERE_O) ? {1'b1, lat_t, lat_o} : {1'b0, lat_t, lat_d};

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      k_nx     = k;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = BUSCA_O;
               k_nx     = '0;
            end
         end
         BUSCA_O: begin
            if (fit_o || at_end) state_nx = INSERE_O;
            else                 k_nx     = k + 1'b1;
         end
         INSERE_O: begin
            state_nx = BUSCA_D;
            k_nx     = k + 1'b1;
         end
         BUSCA_D: begin
            if (fit_d || at_end) state_nx = INSERE_D;
            else                 k_nx     = k + 1'b1;
         end
         INSERE_D: state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // NOTE: the storage array is reset too, because unused entries must read back as zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         k      <= '0;
         cnt    <= '0;
         lat_o  <= '0;
         lat_d  <= '0;
         lat_t  <= '0;
         lat_up <= 1'b0;
         pend   <= 1'b0;
         erro   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         state  <= IDLE;
         k      <= '0;
         cnt    <= '0;
         lat_o  <= '0;
         lat_d  <= '0;
         lat_t  <= '0;
         lat_up <= 1'b0;
         pend   <= 1'b0;
         erro   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state <= state_nx;
         k     <= k_nx;
         erro  <= req_valid && !accept;

         if (accept) begin
            lat_o  <= req_origem;
            lat_d  <= req_destino;
            lat_t  <= req_tipo;
            lat_up <= (req_destino > req_origem);
         end

         if (busy) begin
            if (pop) pend <= 1'b1;
         end else begin
            pend <= 1'b0;
         end

         if (state == INSERE_O || state == INSERE_D) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
               if (CNT_W'(i) > k && CNT_W'(i) <= cnt) mem[i] <= mem[i-1];
            end
            mem[k_idx] <= new_entry;
            cnt        <= cnt + 1'b1;
         end else if (pop_now) begin
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
            cnt          <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_smart_cargo_fila_n.sv
// Scoreboard bench for smart_cargo_fila_n (DEPTH=4): stimulus queues expected queue
// snapshots, a monitor compares them whenever the DUT completes, flags erro, or a snapshot is requested.
module tb_smart_cargo_fila_n;

   logic       clock = 1'b0;
   logic       reset;
   logic       clear;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_origem;
   logic [1:0] req_destino;
   logic [1:0] req_tipo;
   logic [1:0] andar_atual;
   logic       pop;
   logic       head_valid;
   logic [1:0] head_andar;
   logic       head_eh_origem;
   logic [1:0] head_tipo;
   logic [2:0] count;
   logic       busy;
   logic       erro;
   logic [1:0] dbg_addr;
   logic [4:0] dbg_dados;

   smart_cargo_fila_n #(
      .ANDAR_BITS(2), .TIPO_BITS(2), .DEPTH(4), .ADDR_BITS(2)
   ) dut (
      .clock(clock), .reset(reset), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_origem(req_origem), .req_destino(req_destino), .req_tipo(req_tipo),
      .andar_atual(andar_atual), .pop(pop),
      .head_valid(head_valid), .head_andar(head_andar),
      .head_eh_origem(head_eh_origem), .head_tipo(head_tipo),
      .count(count), .busy(busy), .erro(erro),
      .dbg_addr(dbg_addr), .dbg_dados(dbg_dados)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [19:0] q;
      int          cnt;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   logic snap_req = 1'b0;

   localparam logic [4:0] Z = 5'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [4:0] ent(input bit eo, input int t, input int a);
      return {eo, 2'(t), 2'(a)};
   endfunction

   function automatic logic [19:0] qv(input logic [4:0] e0, input logic [4:0] e1,
                                      input logic [4:0] e2, input logic [4:0] e3);
      return {e3, e2, e1, e0};
   endfunction

   task automatic expect_ev(input string n, input logic [19:0] q, input int c);
      exp_t e;
      e.name = n;
      e.q    = q;
      e.cnt  = c;
      sb.push_back(e);
   endtask

   // Monitor: one queue snapshot per triggering event, compared in order against the scoreboard.
   initial begin : monitor
      logic        prev_busy;
      logic [19:0] snapv;
      int          n_ev;
      exp_t        e;
      prev_busy = 1'b0;
      dbg_addr  = '0;
      forever begin
         @(negedge clock);
         n_ev = 0;
         if (erro === 1'b1) n_ev++;
         if (prev_busy === 1'b1 && busy === 1'b0) n_ev++;
         if (snap_req) n_ev++;
         prev_busy = busy;
         if (n_ev > 0) begin
            for (int i = 0; i < 4; i++) begin
               dbg_addr = 2'(i);
               #1;
               snapv[i*5 +: 5] = dbg_dados;
            end
            repeat (n_ev) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output actual=%0h required=no_event", snapv);
               end else begin
                  e = sb.pop_front();
                  check({e.name, "_queue"}, 32'(snapv), 32'(e.q));
                  check({e.name, "_count"}, 32'(count), e.cnt);
               end
            end
         end
      end
   end

   task automatic issue(input int o, input int d, input int t);
      @(posedge clock); #1;
      req_valid   = 1'b1;
      req_origem  = 2'(o);
      req_destino = 2'(d);
      req_tipo    = 2'(t);
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string n);
      int cyc = 0;
      while (busy && cyc < 50) begin
         @(posedge clock); #1;
         cyc++;
      end
      check({n, "_idle"}, 32'(busy), 0);
   endtask

   task automatic send(input string n, input int o, input int d, input int t,
                       input logic [19:0] q, input int c);
      expect_ev(n, q, c);
      issue(o, d, t);
      check({n, "_busy"}, 32'(busy), 1);
      wait_idle(n);
   endtask

   task automatic snap(input string n, input logic [19:0] q, input int c);
      expect_ev(n, q, c);
      snap_req = 1'b1;
      @(posedge clock); #1;
      snap_req = 1'b0;
   endtask

   task automatic do_pop(input string n, input logic [19:0] q, input int c);
      @(posedge clock); #1;
      pop = 1'b1;
      @(posedge clock); #1;
      pop = 1'b0;
      snap(n, q, c);
   endtask

   task automatic reject(input string n, input int o, input int d, input int t,
                         input logic [19:0] q, input int c);
      expect_ev(n, q, c);
      issue(o, d, t);
      check({n, "_erro"}, 32'(erro), 1);
      @(posedge clock); #1;
      check({n, "_erro_end"}, 32'(erro), 0);
   endtask

   task automatic do_clear();
      @(posedge clock); #1;
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      snap("clear", '0, 0);
   endtask

   initial begin : stimulus
      logic [19:0] q_setup;
      reset       = 1'b1;
      clear       = 1'b0;
      req_valid   = 1'b0;
      req_origem  = '0;
      req_destino = '0;
      req_tipo    = '0;
      andar_atual = '0;
      pop         = 1'b0;
      q_setup     = qv(ent(1, 1, 3), ent(0, 1, 0), Z, Z);

      @(posedge clock); #1;
      @(posedge clock); #1;
      check("rst_req_ready", 32'(req_ready), 1);
      check("rst_head_valid", 32'(head_valid), 0);
      check("rst_head", 32'({head_eh_origem, head_tipo, head_andar}), 0);
      check("rst_count", 32'(count), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_erro", 32'(erro), 0);
      check("rst_dbg", 32'(dbg_dados), 0);
      snap("rst", '0, 0);
      reset = 1'b0;

      // Append into an empty queue, then drain it with pops.
      andar_atual = 2'd2;
      send("append", 1, 3, 1, qv(ent(1, 1, 1), ent(0, 1, 3), Z, Z), 2);
      check("append_head_valid", 32'(head_valid), 1);
      check("append_head", 32'({head_eh_origem, head_tipo, head_andar}), 32'(ent(1, 1, 1)));
      do_pop("pop1", qv(ent(0, 1, 3), Z, Z, Z), 1);
      check("pop1_head", 32'({head_eh_origem, head_andar}), 32'({1'b0, 2'd3}));
      do_pop("pop2", '0, 0);
      check("pop2_head_valid", 32'(head_valid), 0);
      do_pop("pop_empty", '0, 0);

      // Ascending ride-along, then full-queue rejections.
      andar_atual = 2'd0;
      send("setup1", 3, 0, 1, q_setup, 2);
      send("ride", 1, 2, 2, qv(ent(1, 2, 1), ent(0, 2, 2), ent(1, 1, 3), ent(0, 1, 0)), 4);
      check("ride_ready", 32'(req_ready), 0);
      reject("full4", 1, 2, 1, qv(ent(1, 2, 1), ent(0, 2, 2), ent(1, 1, 3), ent(0, 1, 0)), 4);
      do_pop("pop_to3", qv(ent(0, 2, 2), ent(1, 1, 3), ent(0, 1, 0), Z), 3);
      check("cnt3_ready", 32'(req_ready), 0);
      reject("full3", 0, 3, 1, qv(ent(0, 2, 2), ent(1, 1, 3), ent(0, 1, 0), Z), 3);

      // Direction filter: origin skips the ascending segment for a downward user.
      do_clear();
      send("setup2", 3, 0, 1, q_setup, 2);
      send("dirf", 2, 1, 3, qv(ent(1, 1, 3), ent(1, 3, 2), ent(0, 3, 1), ent(0, 1, 0)), 4);

      // Malformed requests.
      do_clear();
      reject("same_floor", 2, 2, 1, '0, 0);
      reject("tipo0", 1, 3, 0, '0, 0);

      // Pop during search is deferred; the second pop while pending is dropped.
      send("setup3", 3, 0, 1, q_setup, 2);
      expect_ev("defer_ins", qv(ent(1, 1, 3), ent(1, 3, 2), ent(0, 3, 1), ent(0, 1, 0)), 4);
      issue(2, 1, 3);
      pop = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      pop = 1'b0;
      check("defer_cnt_mid", 32'(count), 2);
      wait_idle("defer");
      @(posedge clock); #1;
      snap("defer_pop", qv(ent(1, 3, 2), ent(0, 3, 1), ent(0, 1, 0), Z), 3);

      // Asynchronous reset during the destination search.
      do_clear();
      send("setup4", 3, 0, 1, q_setup, 2);
      expect_ev("rst_mid", '0, 0);
      issue(2, 1, 3);
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("rst_mid_busy_before", 32'(busy), 1);
      #1;
      reset = 1'b1;
      #1;
      check("rst_mid_count", 32'(count), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_ready", 32'(req_ready), 1);
      @(posedge clock); #1;
      reset = 1'b0;
      andar_atual = 2'd2;
      send("after_rst", 1, 3, 1, qv(ent(1, 1, 1), ent(0, 1, 3), Z, Z), 2);

      repeat (3) begin
         @(posedge clock); #1;
      end
      check("sb_drained", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
